// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_arbiter_if : fetch, load/store and memory-port signals of the arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // load/store requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // single-port memory
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_addr, m_we, m_wdata,
      input  m_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_addr, m_we, m_wdata,
      output m_rdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : shares one single-port memory between fetch and load/store.
// Optional fetch anti-starvation counter built when MEM_ARB_FAIR_EN is defined.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  wire logic     clk,
   input  wire logic     rst,
   mem_arbiter_if.slave  bus_io
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } own_e;

   own_e              own_q, own_d;
   logic              fetch_win;
   logic              starved;
   logic              if_gnt;
   logic              d_gnt;
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [DATA_W-1:0] m_wdata;
   logic              if_rvalid;
   logic              d_rvalid;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must lie in 1..15");
   end

`ifdef MEM_ARB_FAIR_EN
   localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;

   // Counts contentions fetch has lost; a full count hands fetch the next one.
   always_comb begin
      starve_d = starve_q;
      if (!bus_io.if_req || if_gnt) begin
         starve_d = 4'd0;
      end else if (d_gnt && (starve_q != c_STARVE_MAX)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign starved = (starve_q == c_STARVE_MAX);
`else
   assign starved = 1'b0;
`endif

   always_comb begin
      fetch_win = bus_io.if_req && (!bus_io.d_req || starved);
      if_gnt    = !rst && fetch_win;
      d_gnt     = !rst && bus_io.d_req && !fetch_win;

      m_addr  = '0;
      m_we    = 1'b0;
      m_wdata = '0;
      own_d   = OWN_NONE;

      if (if_gnt) begin
         m_addr = bus_io.if_addr;
         own_d  = OWN_IF;
      end else if (d_gnt) begin
         m_addr  = bus_io.d_addr;
         m_we    = bus_io.d_we;
         m_wdata = bus_io.d_wdata;
         if (!bus_io.d_we) begin
            own_d = OWN_D;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own_q <= OWN_NONE;
      end else begin
         own_q <= own_d;
      end
   end

   // Responses are masked during reset so an in-flight read is dropped cleanly.
   assign if_rvalid = !rst && (own_q == OWN_IF);
   assign d_rvalid  = !rst && (own_q == OWN_D);

   assign bus_io.if_gnt    = if_gnt;
   assign bus_io.d_gnt     = d_gnt;
   assign bus_io.m_addr    = m_addr;
   assign bus_io.m_we      = m_we;
   assign bus_io.m_wdata   = m_wdata;
   assign bus_io.if_rvalid = if_rvalid;
   assign bus_io.d_rvalid  = d_rvalid;
   assign bus_io.if_rdata  = if_rvalid ? bus_io.m_rdata : '0;
   assign bus_io.d_rdata   = d_rvalid  ? bus_io.m_rdata : '0;

   a_one_grant : assert property (@(posedge clk) !(if_gnt && d_gnt));
   a_one_rvalid : assert property (@(posedge clk) !(if_rvalid && d_rvalid));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter : directed stimulus, reference-model compare every cycle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk;
   logic rst;
   logic mem_clr;
   int   checks;
   int   failures;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus_io(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'd0, a});
   endfunction

   // Environment memory: registered address, data one cycle later.
   logic [31:0] mem_data [256];
   logic        mem_wr   [256];
   logic [7:0]  mem_aq;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem_wr[i] <= 1'b0;
      end else if (bus.m_we) begin
         mem_data[bus.m_addr[7:0]] <= bus.m_wdata;
         mem_wr[bus.m_addr[7:0]]   <= 1'b1;
      end
      mem_aq <= bus.m_addr[7:0];
   end

   assign bus.m_rdata = mem_wr[mem_aq] ? mem_data[mem_aq] : init_val(mem_aq);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pending response + model memory + lost-contention count.
   logic [31:0] ref_mem [256];
   int          pend_who;   // 0 none, 1 fetch, 2 load
   logic [31:0] pend_data;
   int          lost;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      pend_who  = 0;
      pend_data = '0;
      lost      = 0;
      forever begin
         logic fw, eg_if, eg_d, ev_if, ev_d;
         logic [31:0] ea, ewd;
         logic ewe;
         @(negedge clk);
         fw    = bus.if_req && (!bus.d_req || (FAIR && lost >= STARVE_MAX));
         eg_if = !rst && fw;
         eg_d  = !rst && bus.d_req && !fw;
         ev_if = !rst && (pend_who == 1);
         ev_d  = !rst && (pend_who == 2);
         ea    = eg_if ? bus.if_addr : (eg_d ? bus.d_addr : 32'd0);
         ewe   = eg_d && bus.d_we;
         ewd   = (eg_d && bus.d_we) ? bus.d_wdata : 32'd0;

         chk("if_gnt",    32'(bus.if_gnt),    32'(eg_if));
         chk("d_gnt",     32'(bus.d_gnt),     32'(eg_d));
         chk("if_rvalid", 32'(bus.if_rvalid), 32'(ev_if));
         chk("d_rvalid",  32'(bus.d_rvalid),  32'(ev_d));
         chk("if_rdata",  bus.if_rdata, ev_if ? pend_data : 32'd0);
         chk("d_rdata",   bus.d_rdata,  ev_d  ? pend_data : 32'd0);
         chk("m_addr",    bus.m_addr,   ea);
         chk("m_we",      32'(bus.m_we), 32'(ewe));
         chk("m_wdata",   bus.m_wdata,  ewd);

         if (rst) begin
            pend_who = 0;
            lost     = 0;
         end else begin
            pend_who = 0;
            if (eg_if) begin
               pend_who  = 1;
               pend_data = ref_mem[bus.if_addr[7:0]];
            end else if (eg_d && !bus.d_we) begin
               pend_who  = 2;
               pend_data = ref_mem[bus.d_addr[7:0]];
            end else if (eg_d) begin
               ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
            end
            if (!bus.if_req || eg_if) lost = 0;
            else if (eg_d && lost < STARVE_MAX) lost = lost + 1;
         end
      end
   end

   // One cycle: drive inputs just after posedge, return at the following negedge.
   task automatic cyc(input logic r, input logic ifr, input logic [31:0] ifa,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd);
      @(posedge clk);
      #1;
      mem_clr     = 1'b0;
      rst         = r;
      bus.if_req  = ifr;
      bus.if_addr = ifa;
      bus.d_req   = dr;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      int first;
      checks      = 0;
      failures    = 0;
      mem_clr     = 1'b1;
      rst         = 1'b1;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // reset hold
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      cyc(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);

      // single fetch
      cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("t1_if_gnt", 32'(bus.if_gnt), 32'd1);
      idle();
      chk("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);

      // fetch streaming
      for (int a = 0; a < 4; a++) begin
         cyc(1'b0, 1'b1, 32'(a), 1'b0, 1'b0, 32'd0, 32'd0);
         chk("t2_if_gnt", 32'(bus.if_gnt), 32'd1);
         if (a > 0) chk("t2_if_rdata", bus.if_rdata, 32'hC0DE0000 + 32'(a - 1));
      end
      idle();
      chk("t2_last_rdata", bus.if_rdata, 32'hC0DE0003);

      // contention
      cyc(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'd0);
      chk("t3_d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("t3_if_gnt", 32'(bus.if_gnt), 32'd0);
      cyc(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("t3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
      chk("t3_d_rdata", bus.d_rdata, 32'hC0DE0008);
      chk("t3_if_gnt2", 32'(bus.if_gnt), 32'd1);
      idle();
      chk("t3_if_rdata", bus.if_rdata, 32'hC0DE0004);

      // store then load
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      chk("t4_st_gnt", 32'(bus.d_gnt), 32'd1);
      chk("t4_st_we", 32'(bus.m_we), 32'd1);
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
      chk("t4_st_norvalid", 32'(bus.d_rvalid), 32'd0);
      idle();
      chk("t4_ld_rdata", bus.d_rdata, 32'h12345678);

      // starvation window
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b0, (first == 0), 32'h40, 1'b1, 1'b0, 32'h30 + 32'(k), 32'd0);
         if (bus.if_gnt && first == 0) first = k;
      end
      chk("t5_first_if_gnt", 32'(first), FAIR ? 32'(STARVE_MAX + 1) : 32'd0);
      idle();
      idle();

      // reset with a load in flight
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
      chk("t6_ld_gnt", 32'(bus.d_gnt), 32'd1);
      cyc(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'd0);
      chk("t6_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("t6_d_rdata", bus.d_rdata, 32'd0);
      chk("t6_gnt_sup", 32'({bus.if_gnt, bus.d_gnt}), 32'd0);
      chk("t6_m_addr", bus.m_addr, 32'd0);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      idle();
      chk("t6_post_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      idle();

      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
